// File: rtl/dcache_pkg.sv
// Shared widths, FSM encoding and address field helpers for the
// direct-mapped write-back L1 data cache.
package dcache_pkg;

  localparam int OFFSET_W  = 5;
  localparam int INDEX_W   = 5;
  localparam int TAG_W     = 22;
  localparam int LINE_W    = 256;
  localparam int WORD_W    = 32;
  localparam int WSEL_W    = OFFSET_W - 2;
  localparam int ADDR_BITS = TAG_W + INDEX_W + OFFSET_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [INDEX_W-1:0]   index_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [WSEL_W-1:0]    wsel_t;

  function automatic index_t addr_index(input addr_t addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic tag_t addr_tag(input addr_t addr);
    return addr[OFFSET_W+INDEX_W +: TAG_W];
  endfunction

  function automatic wsel_t addr_word(input addr_t addr);
    return addr[2 +: WSEL_W];
  endfunction

  function automatic addr_t line_addr(input tag_t tag, input index_t index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side buses of the data cache; the cache uses the
// slave view, the pipeline/memory environment the master view.
interface dcache_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [31:0]       cpu_data_i;
  logic [31:0]       cpu_data_o;
  logic              cpu_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: one combinational read port and a
// synchronous line-fill or single-word write port sharing one index.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  index_t            index,
  output logic              rd_valid,
  output logic              rd_dirty,
  output tag_t              rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              line_we,
  input  tag_t              line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              word_we,
  input  wsel_t             word_sel,
  input  logic [WORD_W-1:0] word_data,
  input  logic              clr_dirty
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  tag_t                 tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end else if (clr_dirty) begin
      dirty_q[index] <= 1'b0;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the cleared valid
  // bits make their contents irrelevant, and a reset would prevent RAM mapping.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      tag_q[index]  <= line_tag;
      data_q[index] <= line_data;
    end else if (word_we) begin
      data_q[index][{word_sel, 5'b00000} +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate L1 data cache: hit detection,
// miss FSM (IDLE/WRITEBACK/REFILL) and the line-granular memory interface.
module dcache_controller #(
  parameter int NUM_LINES = 32,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.slave  bus
);
  import dcache_pkg::*;

  state_t            state_q, state_d;
  index_t            req_index_q;
  tag_t              req_tag_q;
  logic              latch_req;

  index_t            cpu_index;
  tag_t              cpu_tag;
  wsel_t             cpu_word;
  index_t            sram_index;

  logic              rd_valid, rd_dirty;
  tag_t              rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              hit;

  logic              line_we, word_we, clr_dirty;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;

  assign cpu_index = addr_index(addr_t'(bus.cpu_addr_i));
  assign cpu_tag   = addr_tag(addr_t'(bus.cpu_addr_i));
  assign cpu_word  = addr_word(addr_t'(bus.cpu_addr_i));

  // During a miss the arrays are addressed by the latched request so that
  // CPU address changes cannot disturb the transfer.
  assign sram_index = (state_q == IDLE) ? cpu_index : req_index_q;
  assign hit        = rd_valid && (rd_tag == cpu_tag);

  dcache_sram #(.NUM_LINES(NUM_LINES)) u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .index     (sram_index),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .line_we   (line_we),
    .line_tag  (req_tag_q),
    .line_data (bus.mem_data_i),
    .word_we   (word_we),
    .word_sel  (cpu_word),
    .word_data (bus.cpu_data_i),
    .clr_dirty (clr_dirty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      req_index_q <= '0;
      req_tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        req_index_q <= cpu_index;
        req_tag_q   <= cpu_tag;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    stall          = 1'b0;
    latch_req      = 1'b0;
    line_we        = 1'b0;
    word_we        = 1'b0;
    clr_dirty      = 1'b0;
    bus.mem_req_o  = 1'b0;
    bus.mem_we_o   = 1'b0;
    mem_addr       = '0;
    bus.mem_data_o = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_i && !hit) begin
          stall     = 1'b1;
          latch_req = 1'b1;
          state_d   = (rd_valid && rd_dirty) ? WRITEBACK : REFILL;
        end else if (bus.cpu_req_i && bus.cpu_we_i) begin
          word_we = 1'b1;
        end
      end
      WRITEBACK: begin
        stall          = 1'b1;
        bus.mem_req_o  = 1'b1;
        bus.mem_we_o   = 1'b1;
        mem_addr       = ADDR_W'(line_addr(rd_tag, req_index_q));
        bus.mem_data_o = rd_data;
        if (bus.mem_ack_i) begin
          clr_dirty = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        stall         = 1'b1;
        bus.mem_req_o = 1'b1;
        mem_addr      = ADDR_W'(line_addr(req_tag_q, req_index_q));
        if (bus.mem_ack_i) begin
          line_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_addr_o = mem_addr;
  // Stall is forced low while reset is held so the pipeline is never frozen
  // by a request presented during reset.
  assign bus.cpu_stall_o = rst_i && stall;
  assign bus.cpu_data_o  = (state_q == IDLE && hit) ?
                           rd_data[{cpu_word, 5'b00000} +: 32] : 32'h0;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a line-granular
// memory model whose ack latency is set per step.
module tb_dcache_controller;

  logic clk;
  logic rst_n;

  dcache_if #(.ADDR_W(32), .LINE_W(256)) bus ();

  dcache_controller #(.NUM_LINES(32), .LINE_W(256), .ADDR_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory model: acks ack_lat cycles after the request is first seen.
  logic [255:0] mem_lines [logic [31:0]];
  int           ack_lat = 0;
  int           ack_cnt = 0;
  int           n_fill = 0;
  int           n_wb = 0;
  logic [31:0]  last_fill_addr = '0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.mem_ack_i = 1'b0;
      ack_cnt = 0;
    end else begin
      if (bus.mem_ack_i) begin
        bus.mem_ack_i = 1'b0;
        ack_cnt = 0;
      end
      if (bus.mem_req_o) begin
        if (ack_cnt == ack_lat) begin
          bus.mem_ack_i = 1'b1;
          if (bus.mem_we_o) begin
            mem_lines[bus.mem_addr_o] = bus.mem_data_o;
            last_wb_addr = bus.mem_addr_o;
            last_wb_data = bus.mem_data_o;
            n_wb++;
          end else begin
            bus.mem_data_i = mem_lines.exists(bus.mem_addr_o) ? mem_lines[bus.mem_addr_o] : '0;
            last_fill_addr = bus.mem_addr_o;
            n_fill++;
          end
        end else begin
          ack_cnt++;
        end
      end else begin
        ack_cnt = 0;
      end
    end
  end

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // One CPU access: count stalled cycles (bounded), sample the hit cycle,
  // then hold the request over the completing edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int stall_cycles, output logic [31:0] rdata, output logic mreq);
    @(negedge clk);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = wdata;
    #1;
    stall_cycles = 0;
    while (bus.cpu_stall_o && stall_cycles < 200) begin
      stall_cycles++;
      @(negedge clk);
      #1;
    end
    rdata = bus.cpu_data_o;
    mreq  = bus.mem_req_o;
    @(posedge clk);
    #1;
    bus.cpu_req_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
  endtask

  logic [255:0] l040, l440, l7e0, lbe0, l840, exp_line;
  int           sc;
  logic [31:0]  rd;
  logic         mr;

  initial begin
    l040 = mk_line(32'hA000_0000);
    l040[31:0] = 32'h1234_5678;
    l440 = mk_line(32'hB000_0000);
    l7e0 = mk_line(32'hC000_0000);
    lbe0 = mk_line(32'hD000_0000);
    l840 = mk_line(32'hE000_0000);
    mem_lines[32'h0000_0040] = l040;
    mem_lines[32'h0000_0440] = l440;
    mem_lines[32'h0000_07E0] = l7e0;
    mem_lines[32'h0000_0BE0] = lbe0;
    mem_lines[32'h0000_0840] = l840;

    // Reset with a request already presented: everything must stay quiet.
    rst_n = 1'b0;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h0000_0040;
    bus.cpu_data_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall",    256'(bus.cpu_stall_o), 256'(0));
    check("rst_mem_req",  256'(bus.mem_req_o),   256'(0));
    check("rst_mem_we",   256'(bus.mem_we_o),    256'(0));
    check("rst_mem_addr", 256'(bus.mem_addr_o),  256'(0));
    check("rst_mem_data", bus.mem_data_o,        256'(0));
    check("rst_cpu_data", 256'(bus.cpu_data_o),  256'(0));
    bus.cpu_req_i = 1'b0;
    rst_n = 1'b1;

    // Clean load miss, A = 3: A + 2 stall cycles.
    ack_lat = 3;
    access(1'b0, 32'h0000_0040, 32'h0, sc, rd, mr);
    check("miss40_stall",     256'(sc),             256'(5));
    check("miss40_data",      256'(rd),             256'(32'h1234_5678));
    check("miss40_fills",     256'(n_fill),         256'(1));
    check("miss40_fill_addr", 256'(last_fill_addr), 256'(32'h40));
    check("miss40_wbs",       256'(n_wb),           256'(0));

    // Hit on another word of the same line.
    access(1'b0, 32'h0000_0044, 32'h0, sc, rd, mr);
    check("hit44_stall", 256'(sc),     256'(0));
    check("hit44_data",  256'(rd),     256'(32'hA000_0001));
    check("hit44_mreq",  256'(mr),     256'(0));
    check("hit44_fills", 256'(n_fill), 256'(1));

    // Store hit, then reload; neighbouring word and memory untouched.
    access(1'b1, 32'h0000_0048, 32'hDEAD_BEEF, sc, rd, mr);
    check("st48_stall", 256'(sc), 256'(0));
    check("st48_mreq",  256'(mr), 256'(0));
    access(1'b0, 32'h0000_0048, 32'h0, sc, rd, mr);
    check("ld48_data", 256'(rd), 256'(32'hDEAD_BEEF));
    access(1'b0, 32'h0000_004C, 32'h0, sc, rd, mr);
    check("ld4c_data", 256'(rd), 256'(32'hA000_0003));
    check("mem40_untouched", mem_lines[32'h0000_0040], l040);
    check("st48_wbs",        256'(n_wb),               256'(0));

    // Conflict miss on index 2 with dirty victim, A = 3: 2A + 3 stall cycles.
    access(1'b0, 32'h0000_0448, 32'h0, sc, rd, mr);
    exp_line = l040;
    exp_line[64 +: 32] = 32'hDEAD_BEEF;
    check("miss448_stall",     256'(sc),             256'(9));
    check("miss448_wbs",       256'(n_wb),           256'(1));
    check("miss448_wb_addr",   256'(last_wb_addr),   256'(32'h40));
    check("miss448_wb_data",   last_wb_data,         exp_line);
    check("miss448_fills",     256'(n_fill),         256'(2));
    check("miss448_fill_addr", 256'(last_fill_addr), 256'(32'h440));
    check("miss448_data",      256'(rd),             256'(32'hB000_0002));

    // Store miss at index 31 (clean victim), A = 1: write-allocate.
    ack_lat = 1;
    access(1'b1, 32'h0000_07E4, 32'hCAFE_F00D, sc, rd, mr);
    check("st7e4_stall",     256'(sc),             256'(3));
    check("st7e4_fill_addr", 256'(last_fill_addr), 256'(32'h7E0));
    check("st7e4_wbs",       256'(n_wb),           256'(1));
    access(1'b0, 32'h0000_07E4, 32'h0, sc, rd, mr);
    check("ld7e4_stall", 256'(sc), 256'(0));
    check("ld7e4_data",  256'(rd), 256'(32'hCAFE_F00D));

    // Evict that line with A = 0: proves it was dirty.
    ack_lat = 0;
    access(1'b0, 32'h0000_0BE4, 32'h0, sc, rd, mr);
    exp_line = l7e0;
    exp_line[32 +: 32] = 32'hCAFE_F00D;
    check("missbe4_stall",   256'(sc),           256'(3));
    check("missbe4_wb_addr", 256'(last_wb_addr), 256'(32'h7E0));
    check("missbe4_wb_data", last_wb_data,       exp_line);
    check("missbe4_data",    256'(rd),           256'(32'hD000_0001));

    // Reset in the middle of a refill (A = 10), then the same load misses again.
    ack_lat = 10;
    @(negedge clk);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h0000_0840;
    repeat (3) @(negedge clk);
    #1;
    check("refill_req",  256'(bus.mem_req_o),  256'(1));
    check("refill_we",   256'(bus.mem_we_o),   256'(0));
    check("refill_addr", 256'(bus.mem_addr_o), 256'(32'h840));
    rst_n = 1'b0;
    #1;
    check("midrst_req",   256'(bus.mem_req_o),   256'(0));
    check("midrst_stall", 256'(bus.cpu_stall_o), 256'(0));
    check("midrst_fills", 256'(n_fill),          256'(4));
    bus.cpu_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h0000_0840, 32'h0, sc, rd, mr);
    check("post_rst_stall",     256'(sc),             256'(12));
    check("post_rst_fill_addr", 256'(last_fill_addr), 256'(32'h840));
    check("post_rst_data",      256'(rd),             256'(32'hE000_0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
